// File: rtl/shift_right_seq.sv
// shift_right_seq: bit-serial right shifter under a start/busy/done handshake.
// Shifts one position per clock in logical (fixed fill) or arithmetic mode.
// Optional feature macro: SHIFT_RIGHT_ROTATE_EN adds i_rotate (rotate right).
module shift_right_seq #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_data,
   input  logic [AMT_W-1:0] i_amt,
   input  logic             i_fill,
   input  logic             i_arith,
`ifdef SHIFT_RIGHT_ROTATE_EN
   input  logic             i_rotate,
`endif
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_shiftedData
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_nxt;
   logic [WIDTH-1:0]   work_q, work_nxt;
   logic [AMT_W-1:0]   cnt_q, cnt_nxt;
   logic               fill_q, fill_nxt;
   logic [WIDTH-1:0]   result_q, result_nxt;
   logic               busy_q, done_q;
   logic               ins_bit_c;
`ifdef SHIFT_RIGHT_ROTATE_EN
   logic               rot_q, rot_nxt;
`endif

   // Bit inserted at the MSB on each shift step
   always_comb begin
      ins_bit_c = fill_q;
`ifdef SHIFT_RIGHT_ROTATE_EN
      if (rot_q) begin
         ins_bit_c = work_q[0];
      end
`endif
   end

   // Next-state and datapath update
   always_comb begin
      state_nxt  = state_q;
      work_nxt   = work_q;
      cnt_nxt    = cnt_q;
      fill_nxt   = fill_q;
      result_nxt = result_q;
`ifdef SHIFT_RIGHT_ROTATE_EN
      rot_nxt    = rot_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_start) begin
               work_nxt  = i_data;
               fill_nxt  = i_arith ? i_data[WIDTH-1] : i_fill;
               // Out-of-range amounts pass the operand through unchanged
               cnt_nxt   = (i_amt > AMT_W'(WIDTH)) ? '0 : i_amt;
`ifdef SHIFT_RIGHT_ROTATE_EN
               rot_nxt   = i_rotate;
`endif
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != '0) begin
               work_nxt = {ins_bit_c, work_q[WIDTH-1:1]};
               cnt_nxt  = cnt_q - AMT_W'(1);
            end else begin
               result_nxt = work_q;
               state_nxt  = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, datapath and status registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         work_q   <= '0;
         cnt_q    <= '0;
         fill_q   <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SHIFT_RIGHT_ROTATE_EN
         rot_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_nxt;
         work_q   <= work_nxt;
         cnt_q    <= cnt_nxt;
         fill_q   <= fill_nxt;
         result_q <= result_nxt;
         busy_q   <= (state_nxt != IDLE);
         done_q   <= (state_nxt == DONE);
`ifdef SHIFT_RIGHT_ROTATE_EN
         rot_q    <= rot_nxt;
`endif
      end
   end

   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_shiftedData = result_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: directed plus randomized checks of shift_right_seq
// against an arithmetic reference model.
module tb_shift_right_seq;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned AMT_W = 4;
`ifdef SHIFT_RIGHT_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] data;
   logic [AMT_W-1:0] amt;
   logic             fill;
   logic             arith;
`ifdef SHIFT_RIGHT_ROTATE_EN
   logic             rotate;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] res;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] last_res;

   shift_right_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_data        (data),
      .i_amt         (amt),
      .i_fill        (fill),
      .i_arith       (arith),
`ifdef SHIFT_RIGHT_ROTATE_EN
      .i_rotate      (rotate),
`endif
      .o_busy        (busy),
      .o_done        (done),
      .o_shiftedData (res)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: right shift by amt with fill, as plain arithmetic
   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int a,
                                              input logic f, input logic ar, input logic ro);
      logic [2*WIDTH-1:0] dd;
      logic [WIDTH-1:0]   ones;
      logic               fb;
      if (a > int'(WIDTH)) return d;
      if (ro) begin
         dd = {d, d} >> a;
         return dd[WIDTH-1:0];
      end
      fb   = ar ? d[WIDTH-1] : f;
      ones = '1;
      return (d >> a) | (fb ? ~(ones >> a) : '0);
   endfunction

   task automatic set_rot(input logic r);
`ifdef SHIFT_RIGHT_ROTATE_EN
      rotate = r;
`else
      if (r) $display("rotate requested without feature");
`endif
   endtask

   // One operation: start, optionally disturb inputs while busy, check latency and result
   task automatic run_op(input string tag, input logic [WIDTH-1:0] d, input int a,
                         input logic f, input logic ar, input logic ro, input bit noisy);
      logic [WIDTH-1:0] exp;
      int eff;
      int k;
      exp = model(d, a, f, ar, ro);
      eff = (a > int'(WIDTH)) ? 0 : a;
      @(negedge clk);
      data = d; amt = AMT_W'(a); fill = f; arith = ar; set_rot(ro); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_acc"}, 32'(busy), 32'd1);
      k = 41;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            k = c;
            break;
         end
         check({tag, "_hold"}, 32'(res), 32'(last_res));
         if (noisy) begin
            start = 1'($urandom);
            data  = WIDTH'($urandom);
            amt   = AMT_W'($urandom);
            fill  = 1'($urandom);
            arith = 1'($urandom);
         end
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(k), 32'(eff + 1));
      check({tag, "_result"}, 32'(res), 32'(exp));
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_result_held"}, 32'(res), 32'(exp));
      last_res = exp;
   endtask

   initial begin
      int n_done;
      rst = 1'b1; start = 1'b0; data = '0; amt = '0; fill = 1'b0; arith = 1'b0;
      set_rot(1'b0);
      last_res = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_res", 32'(res), 32'd0);

      run_op("logical", 8'hB4, 3, 1'b0, 1'b0, 1'b0, 1'b0);
      check("logical_const", 32'(last_res), 32'h16);
      run_op("arith", 8'h90, 2, 1'b0, 1'b1, 1'b0, 1'b0);
      check("arith_const", 32'(res), 32'hE4);
      run_op("fill8", 8'h01, 8, 1'b1, 1'b0, 1'b0, 1'b0);
      check("fill8_const", 32'(res), 32'hFF);
      run_op("amt0", 8'h3C, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("amt_big", 8'h5A, 12, 1'b1, 1'b1, 1'b0, 1'b0);
      check("amt_big_const", 32'(res), 32'h5A);
      run_op("arith8", 8'hA5, 8, 1'b0, 1'b1, 1'b0, 1'b0);
      run_op("noisy", 8'hB4, 3, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a shift aborts it
      @(negedge clk);
      data = 8'hF0; amt = 4'd7; fill = 1'b1; arith = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_res", 32'(res), 32'd0);
      n_done = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("midrst_no_done", 32'(n_done), 32'd0);
      last_res = '0;
      run_op("after_rst", 8'h81, 1, 1'b1, 1'b0, 1'b0, 1'b0);

      if (ROT_EN) begin
         run_op("rot1", 8'h81, 1, 1'b0, 1'b0, 1'b1, 1'b0);
         check("rot1_const", 32'(res), 32'hC0);
         run_op("rot8", 8'h81, 8, 1'b1, 1'b1, 1'b1, 1'b0);
         check("rot8_const", 32'(res), 32'h81);
         run_op("rot_big", 8'h6B, 13, 1'b1, 1'b0, 1'b1, 1'b0);
      end

      for (int i = 0; i < 150; i++) begin
         run_op("rand", WIDTH'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                1'($urandom), ROT_EN ? 1'($urandom) : 1'b0, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
